// File: rtl/key_input_pio.sv
// Purpose : Avalon-MM input PIO: sync, debounce, edge capture and IRQ for KEY/SW pins.
// Latency : pin->sync_q 2 clk; debounced after DB_COUNT ticks (or +1 clk when undebounced); read data 1 clk.
// Backpr. : none; the slave never stalls, so every READ/WRITE is accepted in the cycle it is sampled.
//
// Ports:
//   CLK, RST_N            clock and asynchronous active-low reset (release is synchronised here)
//   PIN_IN[WIDTH]         raw asynchronous button/switch inputs
//   ADDRESS, READ, WRITE, WRITEDATA, READDATA   Avalon-MM slave (0 data, 1 reserved, 2 irq_mask, 3 edge_cap)
//   IRQ                   registered level interrupt = |(edge_cap & irq_mask)
//
// Build option: define KEY_INPUT_PIO_DEBOUNCE_EN to include the prescaler and per-bit
// debounce counters. Without it the debounced state is sync_q delayed by one register.

module key_input_pio #(
  parameter int                WIDTH     = 4,
  parameter int                TICK_DIV  = 50000,
  parameter int                DB_COUNT  = 8,
  parameter int                EDGE_TYPE = 1,
  parameter logic [WIDTH-1:0]  INIT_VAL  = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] PIN_IN,
  input  logic [1:0]       ADDRESS,
  input  logic             READ,
  input  logic             WRITE,
  input  logic [31:0]      WRITEDATA,
  output logic [31:0]      READDATA,
  output logic             IRQ
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  // Bad parameter combinations are caught at elaboration rather than
  // producing silently odd hardware.
  if (WIDTH < 1 || WIDTH > 32 || TICK_DIV < 2 || DB_COUNT < 1 || DB_COUNT > 255 ||
      EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_param_check
    $error("key_input_pio: parameter out of range");
  end

  // ---------------------------------------------------------------------
  // Reset: asserted asynchronously, released on the second CLK edge after
  // RST_N rises so every flop below leaves reset in the same cycle.
  // ---------------------------------------------------------------------
  logic [1:0] rst_ff;
  logic       rst_n_i;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_ff <= 2'b00;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end

  assign rst_n_i = rst_ff[1];

  // ---------------------------------------------------------------------
  // Two-flop synchroniser. Reset to INIT_VAL so that idle (released)
  // active-low keys do not look like a press right after reset.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_a <= INIT_VAL;
      sync_q <= INIT_VAL;
    end else begin
      sync_a <= PIN_IN;
      sync_q <= sync_a;
    end
  end

  // ---------------------------------------------------------------------
  // Debounced state. db_nxt is the value db_q takes on the next edge; the
  // edge detector compares the two so edge_cap sets in the same cycle as
  // the debounced bit changes.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_nxt;

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      CNT_LAST = 8'(DB_COUNT - 1);

  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic [WIDTH-1:0][7:0] db_cnt;
  logic [WIDTH-1:0][7:0] cnt_nxt;

  // Sample tick: one cycle per TICK_DIV, asserted on the wrap.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i)  pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  // A bit flips only after DB_COUNT consecutive ticks that all saw the
  // synchronised pin differ from the debounced level; any agreeing tick
  // restarts the count. The >= compare keeps the counter from ever
  // running past the threshold.
  always_comb begin
    db_nxt  = db_q;
    cnt_nxt = db_cnt;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == db_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (db_cnt[i] >= CNT_LAST) begin
          db_nxt[i]  = ~db_q[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = db_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) db_cnt <= '0;
    else          db_cnt <= cnt_nxt;
  end
`else
  // No filtering: one extra register stage behind the synchroniser.
  always_comb begin
    db_nxt = sync_q;
  end
`endif

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) db_q <= INIT_VAL;
    else          db_q <= db_nxt;
  end

  // ---------------------------------------------------------------------
  // Edge detection and capture
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;

  assign rise = ~db_q &  db_nxt;
  assign fall =  db_q & ~db_nxt;

  always_comb begin
    if (EDGE_TYPE == 0)      edge_hit = rise;
    else if (EDGE_TYPE == 1) edge_hit = fall;
    else                     edge_hit = rise | fall;
  end

  logic             wr_mask;
  logic             wr_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr_bits;

  assign wr_mask  = WRITE && (ADDRESS == ADDR_MASK);
  assign wr_cap   = WRITE && (ADDRESS == ADDR_CAP);
  assign clr_bits = wr_cap ? WRITEDATA[WIDTH-1:0] : '0;

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i)     irq_mask <= '0;
    else if (wr_mask) irq_mask <= WRITEDATA[WIDTH-1:0];
  end

  // The OR with edge_hit comes after the clear, so a new edge arriving in
  // the same cycle as a write-1-to-clear leaves the bit set.
  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~clr_bits) | edge_hit;
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) IRQ <= 1'b0;
    else          IRQ <= |(edge_cap & irq_mask);
  end

  // ---------------------------------------------------------------------
  // Read path: registered, pre-write values (a simultaneous write lands on
  // the same edge the read data is captured, so the read sees the old value).
  // ---------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (ADDRESS)
      ADDR_DATA: rd_mux[WIDTH-1:0] = db_q;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) READDATA <= '0;
    else if (READ) READDATA <= rd_mux;
  end

  // Upper write-data bits have no storage behind them.
  logic wdata_unused;
  assign wdata_unused = ^WRITEDATA;

endmodule

// File: tb/tb_key_input_pio.sv
module tb_key_input_pio;

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  PIN_IN;
  logic [1:0]  ADDRESS;
  logic        READ;
  logic        WRITE;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  key_input_pio #(
    .WIDTH(4), .TICK_DIV(4), .DB_COUNT(3), .EDGE_TYPE(1), .INIT_VAL(4'hF)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PIN_IN(PIN_IN), .ADDRESS(ADDRESS),
    .READ(READ), .WRITE(WRITE), .WRITEDATA(WRITEDATA),
    .READDATA(READDATA), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge CLK);
    ADDRESS = a; READ = 1'b1;
    @(posedge CLK); #1;
    d = READDATA;
    READ = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    @(negedge CLK);
    ADDRESS = a; WRITE = 1'b1; WRITEDATA = wd;
    @(posedge CLK); #1;
    WRITE = 1'b0;
  endtask

  // Drive pin, then read the address every cycle (optionally also writing it)
  // until (READDATA & m) == v or the cycle budget runs out.
  task automatic poll(input logic [3:0] pin, input logic [1:0] a, input logic [31:0] m,
                      input logic [31:0] v, input bit do_wr, input logic [31:0] wd,
                      input int bound, output bit ok, output int n,
                      output logic irq_hit, output logic irq_prev);
    ok = 1'b0; n = 0; irq_hit = 1'b0; irq_prev = IRQ;
    @(negedge CLK);
    PIN_IN = pin; ADDRESS = a; READ = 1'b1; WRITE = do_wr; WRITEDATA = wd;
    while (!ok && n < bound) begin
      @(posedge CLK); #1;
      n++;
      if ((READDATA & m) == v) begin
        ok = 1'b1; irq_hit = IRQ;
      end else begin
        irq_prev = IRQ;
      end
    end
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          ok;
    int          n;
    logic        ih, ip;

    RST_N = 1'b1; PIN_IN = 4'hA; ADDRESS = 2'd0; READ = 1'b0; WRITE = 1'b0; WRITEDATA = '0;
    #2 RST_N = 1'b0;
    READ = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_readdata", READDATA, 32'h0);
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    READ = 1'b0;

    // Release and read before any filtered value can have arrived.
    @(negedge CLK) RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    rd(2'd0, d); chk("first_read_init", d, 32'hF);

    poll(4'hA, 2'd0, 32'hF, 32'hA, 1'b0, 0, 20, ok, n, ih, ip);
    chk("accept_A", {31'b0, ok}, 32'h1);
    rd(2'd3, d); chk("cap_after_A", d, 32'h5);
    chk("irq_after_A", {31'b0, IRQ}, 32'h0);

    // Back to all ones (rising edges are not captured), then clear.
    poll(4'hF, 2'd0, 32'hF, 32'hF, 1'b0, 0, 20, ok, n, ih, ip);
    chk("accept_F", {31'b0, ok}, 32'h1);
    rd(2'd3, d); chk("cap_rise_ignored", d, 32'h5);
    wr(2'd3, 32'hF);
    rd(2'd3, d); chk("cap_cleared", d, 32'h0);

    // Short glitch on bit 0.
    @(negedge CLK) PIN_IN = 4'hE;
    repeat (6) @(negedge CLK);
    PIN_IN = 4'hF;
    repeat (20) @(posedge CLK);
    rd(2'd0, d); chk("bounce_data", d, 32'hF);
    rd(2'd3, d); chk("bounce_cap", d, DB_EN ? 32'h0 : 32'h1);
    chk("bounce_irq", {31'b0, IRQ}, 32'h0);
    wr(2'd3, 32'hF);

    // Falling edge on bit 0 with it unmasked.
    wr(2'd2, 32'h1);
    rd(2'd2, d); chk("mask_rd", d, 32'h1);
    poll(4'hE, 2'd3, 32'h1, 32'h1, 1'b0, 0, 30, ok, n, ih, ip);
    chk("fall_seen", {31'b0, ok}, 32'h1);
    if (DB_EN) chk("fall_latency_range", {31'b0, (n >= 12 && n <= 15)}, 32'h1);
    else       chk("fall_latency", n, 32'd4);
    chk("irq_with_cap", {31'b0, ih}, 32'h1);
    chk("irq_before_cap", {31'b0, ip}, 32'h0);
    rd(2'd0, d); chk("data_E", d, 32'hE);

    // Write-1-to-clear: IRQ drops one cycle after the write.
    wr(2'd3, 32'h1);
    chk("irq_hold_at_clear", {31'b0, IRQ}, 32'h1);
    @(posedge CLK); #1;
    chk("irq_fall_after_clear", {31'b0, IRQ}, 32'h0);
    rd(2'd3, d); chk("cap_zero_after_clear", d, 32'h0);

    // Bit 2 falls while bit 2 is being cleared every cycle; the edge must
    // still be visible (read returns the pre-write value).
    poll(4'hA, 2'd3, 32'h4, 32'h4, 1'b1, 32'h4, 30, ok, n, ih, ip);
    chk("race_edge_wins", {31'b0, ok}, 32'h1);
    chk("race_irq_masked", {31'b0, IRQ}, 32'h0);
    rd(2'd3, d); chk("race_cap_after", d, 32'h0);

    // Masked edge on bit 3, then unmask.
    wr(2'd2, 32'h0);
    poll(4'h2, 2'd3, 32'h8, 32'h8, 1'b0, 0, 30, ok, n, ih, ip);
    chk("mask_edge_seen", {31'b0, ok}, 32'h1);
    chk("mask_irq_low", {31'b0, ih}, 32'h0);
    rd(2'd3, d); chk("mask_cap_8", d, 32'h8);
    wr(2'd2, 32'h8);
    chk("unmask_irq_not_yet", {31'b0, IRQ}, 32'h0);
    @(posedge CLK); #1;
    chk("unmask_irq_rise", {31'b0, IRQ}, 32'h1);
    rd(2'd2, d); chk("mask_rd_8", d, 32'h8);

    // Register map corners.
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d); chk("reserved_zero", d, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, d); chk("data_ro", d, 32'h2);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d); chk("mask_width", d, 32'hF);

    // Reset in the middle of a debounce on bit 1.
    @(negedge CLK) PIN_IN = 4'h0;
    repeat (9) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b0;
    #1;
    chk("rst2_readdata", READDATA, 32'h0);
    chk("rst2_irq", {31'b0, IRQ}, 32'h0);
    PIN_IN = 4'hF;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    rd(2'd2, d); chk("rst2_mask", d, 32'h0);
    rd(2'd3, d); chk("rst2_cap", d, 32'h0);
    rd(2'd0, d); chk("rst2_data", d, 32'hF);
    repeat (20) @(posedge CLK);
    rd(2'd3, d); chk("rst2_no_spurious", d, 32'h0);
    rd(2'd0, d); chk("rst2_data_late", d, 32'hF);
    chk("rst2_irq_late", {31'b0, IRQ}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
